// File: rtl/fb_write_arbiter.sv
// Write-port sequencer for the VGA frame buffer. It fills the buffer with a constant,
// gives capture absolute priority, and lets a rate-limited overlay in during a fill.
module fb_write_arbiter #(
    parameter int ADDR_W     = 18,
    parameter int FB_WORDS   = 153600,
    parameter int STARVE_MAX = 15
) (
    input  logic              dotclk,
    input  logic              reset_n,
    input  logic              cap_valid,
    input  logic [ADDR_W-1:0] cap_addr,
    input  logic              cap_data,
    input  logic              ovl_valid,
    input  logic [ADDR_W-1:0] ovl_addr,
    input  logic              ovl_data,
    output logic              ovl_ready,
    input  logic              clr_start,
    input  logic              clr_value,
    output logic [ADDR_W-1:0] waddr,
    output logic              wdata,
    output logic              wren,
    output logic              clr_busy,
    output logic              clr_done
);

    typedef enum logic {CLEAR, RUN} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(FB_WORDS - 1);
    localparam logic [7:0]        STARVE_LIM = 8'(STARVE_MAX);

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;
    logic              fill;
    logic [7:0]        starve_cnt;

    logic starved;
    logic ovl_grant;
    logic clr_grant;

    // ovl_ready must never depend on ovl_valid, so the handshake cannot loop.
    assign starved   = (starve_cnt >= STARVE_LIM);
    assign ovl_ready = !cap_valid && ((state == RUN) || starved);
    assign ovl_grant = ovl_valid && ovl_ready;
    assign clr_grant = (state == CLEAR) && !cap_valid && !ovl_grant && !clr_start;

    always_ff @(posedge dotclk) begin
        if (!reset_n) begin
            state      <= CLEAR;
            clr_ptr    <= '0;
            fill       <= 1'b0;
            starve_cnt <= 8'd0;
            wren       <= 1'b0;
            waddr      <= '0;
            wdata      <= 1'b0;
            clr_busy   <= 1'b1;
            clr_done   <= 1'b0;
        end else begin
            clr_done <= 1'b0;

            if (cap_valid) begin
                wren  <= 1'b1;
                waddr <= cap_addr;
                wdata <= cap_data;
            end else if (ovl_grant) begin
                wren  <= 1'b1;
                waddr <= ovl_addr;
                wdata <= ovl_data;
            end else if (clr_grant) begin
                wren  <= 1'b1;
                waddr <= clr_ptr;
                wdata <= fill;
            end else begin
                wren <= 1'b0;
            end

            if ((state == CLEAR) && ovl_valid && !ovl_ready) begin
                if (starve_cnt != 8'hFF)
                    starve_cnt <= starve_cnt + 8'd1;
            end else begin
                starve_cnt <= 8'd0;
            end

            // A restart outranks everything, including completion of the current fill.
            if (clr_start) begin
                fill     <= clr_value;
                clr_ptr  <= '0;
                state    <= CLEAR;
                clr_busy <= 1'b1;
            end else if (clr_grant) begin
                if (clr_ptr == LAST_ADDR) begin
                    state    <= RUN;
                    clr_ptr  <= '0;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b1;
                end else begin
                    clr_ptr <= clr_ptr + ADDR_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/fb_write_arbiter.md
# fb_write_arbiter

Sequencer and arbiter for the write port of the dual-port frame-buffer RAM that the VGA output side reads. It sits between the RAM write port and three requesters: the Model 4 capture path (one pixel per dot clock, never stalls), an internal clear/fill engine, and a low-priority overlay writer (status text, test patterns) with a valid/ready handshake. After reset, and whenever requested, it fills the whole frame buffer with a constant, then steals idle write cycles so capture is never delayed.

## Interface
- ADDR_W, 18: RAM write-address width.
- FB_WORDS, 153600: frame-buffer size in pixels (640x240). Must satisfy 2 ≤ FB_WORDS ≤ 2^ADDR_W.
- STARVE_MAX, 15: consecutive cycles the overlay may be refused during a clear before it is forced a slot. Range 1..255.

Ports:
- dotclk, in, 1: sole clock. All logic is on the rising edge.
- reset_n, in, 1: synchronous, active-low reset.
- cap_valid, in, 1: capture pixel present this cycle.
- cap_addr, in, ADDR_W: capture pixel address.
- cap_data, in, 1: capture pixel value.
- ovl_valid, in, 1: overlay write request.
- ovl_addr, in, ADDR_W: overlay address.
- ovl_data, in, 1: overlay pixel value.
- ovl_ready, out, 1: combinational. The overlay write is accepted when ovl_valid && ovl_ready.
- clr_start, in, 1: single-cycle pulse that starts or restarts a fill.
- clr_value, in, 1: fill value, sampled on clr_start.
- waddr, out, ADDR_W: registered RAM write address.
- wdata, out, 1: registered RAM write data.
- wren, out, 1: registered RAM write enable.
- clr_busy, out, 1: registered. High while a fill is in progress.
- clr_done, out, 1: registered, one-cycle pulse when a fill completes.

## Operation
- **States:** CLEAR and RUN. The block also holds these registers:
  - clr_ptr: ADDR_W bits.
  - fill value: 1 bit.
  - starve_cnt: 8 bits, saturating.
- **Reset** (reset_n low at a clock edge):
  - state ← CLEAR, clr_ptr ← 0, fill ← 0, starve_cnt ← 0.
  - wren ← 0, waddr ← 0, wdata ← 0, clr_busy ← 1, clr_done ← 0.
  - The power-up fill is automatic. Reset asserted mid-fill restarts the fill from address 0 with value 0.
- **Per-cycle grant priority:** exactly one writer or none.
  1. Capture wins whenever cap_valid = 1. It is unconditional and never refused.
  2. Overlay wins if ovl_valid = 1, capture is idle, and either state = RUN or starve_cnt ≥ STARVE_MAX.
  3. Clear wins if state = CLEAR, capture is idle, and the overlay is not granted.
  4. Otherwise no write occurs.
- **ovl_ready** = !cap_valid && (state = RUN || starve_cnt ≥ STARVE_MAX). It depends only on the current cycle's inputs and registers, never on ovl_valid.
- **starve_cnt:**
  - Increments, saturating at 255, on cycles with ovl_valid && !ovl_ready && state = CLEAR.
  - Clears to 0 on an overlay grant, when ovl_valid = 0, or in RUN.
- **Clear write:**
  - Writes waddr = clr_ptr, wdata = fill, then clr_ptr increments.
  - When the write at clr_ptr = FB_WORDS−1 is issued: state → RUN, clr_ptr → 0, clr_busy → 0, and clr_done pulses 1 on the same registered edge as that final wren.
- **clr_start:**
  - In either state, it latches fill ← clr_value, sets clr_ptr ← 0, state ← CLEAR, clr_busy ← 1.
  - A clear write scheduled for that same cycle is suppressed, so the address sequence always restarts cleanly at 0.
  - If clr_start coincides with the final clear write, the restart wins and clr_done does not pulse.
- **Boundary rules:**
  - Capture writes during CLEAR are honoured. Capture pixels written at addresses the fill has not yet reached will later be overwritten by the fill (accepted behaviour).
  - Addresses are passed through unmodified. No range check is applied to cap_addr or ovl_addr.

## Timing
- Latency is one cycle. The grant decision in cycle N appears on waddr/wdata/wren after edge N+1.
- When no writer is granted, wren = 0 and waddr/wdata hold their previous values.
- Fill duration with no capture or overlay traffic: exactly FB_WORDS cycles from reset release (or from the clr_start edge) to the clr_done pulse.
- With capture active, the fill takes FB_WORDS plus the number of capture-occupied cycles.
- The overlay in CLEAR under continuous valid is guaranteed one grant every STARVE_MAX+1 capture-free cycles.
- ovl_ready has a combinational path only from cap_valid. It has no path from ovl_valid.

## Test plan
- **Reset fill** (FB_WORDS = 16, no traffic): after reset_n rises, addresses 0..15 are each written with 0 on consecutive cycles. clr_done pulses with the address-15 write. clr_busy is then 0 and wren is 0.
- **Capture priority:** during a fill, cap_valid=1 for 3 cycles at addr 100..102 with data 1. The RAM sees 100, 101, 102 in those slots, the clear pauses at ptr k, then resumes at k. Total fill = 16 + 3 cycles.
- **Overlay starvation** (STARVE_MAX = 3): ovl_valid held during CLEAR with no capture. Exactly 1 overlay write occurs per 4 cycles and ovl_ready is high on every 4th cycle. In RUN, ovl_ready tracks !cap_valid each cycle.
- **Restart:** clr_start with clr_value=1 at clr_ptr = 7. The next clear write is address 0 with data 1, 16 writes follow, and one clr_done pulse occurs.
- **Collision:** clr_start coincides with the address-15 write. No clr_done pulse occurs, the refill begins at 0, and clr_busy stays 1.
- **Mid-fill reset:** reset_n low for 1 cycle at ptr 9. All outputs take their reset values, and the fill restarts at 0 with value 0 even if the previous fill value was 1.
